// File: rtl/kbd_pkg.sv
// Shared definitions for the PS/2 Set-2 scan-code decoder: FSM states,
// protocol byte values, modifier key codes and mods bit positions.
package kbd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_E0,
    ST_F0,
    ST_E0F0,
    ST_PAUSE
  } kbd_state_t;

  localparam logic [7:0] SC_E0     = 8'hE0;
  localparam logic [7:0] SC_F0     = 8'hF0;
  localparam logic [7:0] SC_E1     = 8'hE1;
  localparam logic [7:0] SC_AA     = 8'hAA;
  localparam logic [7:0] SC_FA     = 8'hFA;
  localparam logic [7:0] SC_FE     = 8'hFE;
  localparam logic [7:0] SC_EE     = 8'hEE;
  localparam logic [7:0] SC_OVR_LO = 8'h00;
  localparam logic [7:0] SC_OVR_HI = 8'hFF;

  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_RSHIFT = 8'h59;
  localparam logic [7:0] SC_CTRL   = 8'h14;  // left plain, right with E0
  localparam logic [7:0] SC_CAPS   = 8'h58;
  localparam logic [7:0] SC_PAUSE  = 8'h77;

  localparam logic [2:0] PAUSE_SKIP = 3'd7;

  localparam int MOD_SHIFT = 0;
  localparam int MOD_CTRL  = 1;
  localparam int MOD_CAPS  = 2;

endpackage

// File: rtl/kbd_ascii_lut.sv
// Combinational Set-2 make-code to ASCII lookup (US layout subset).
// Only built into the decoder when KBD_DEC_ASCII_EN is defined.
module kbd_ascii_lut
  import kbd_pkg::*;
(
  input  logic [7:0] i_code,
  input  logic       i_ext,
  input  logic       i_shift,
  input  logic       i_caps,
  input  logic       i_ctrl,
  output logic       o_valid,
  output logic [7:0] o_ascii
);

  logic [4:0] w_letter;
  logic       w_dig_hit;
  logic [3:0] w_digit;
  logic [7:0] w_sym;

  always_comb begin
    w_letter = 5'd0;
    case (i_code)
      8'h1C: w_letter = 5'd1;   8'h32: w_letter = 5'd2;   8'h21: w_letter = 5'd3;
      8'h23: w_letter = 5'd4;   8'h24: w_letter = 5'd5;   8'h2B: w_letter = 5'd6;
      8'h34: w_letter = 5'd7;   8'h33: w_letter = 5'd8;   8'h43: w_letter = 5'd9;
      8'h3B: w_letter = 5'd10;  8'h42: w_letter = 5'd11;  8'h4B: w_letter = 5'd12;
      8'h3A: w_letter = 5'd13;  8'h31: w_letter = 5'd14;  8'h44: w_letter = 5'd15;
      8'h4D: w_letter = 5'd16;  8'h15: w_letter = 5'd17;  8'h2D: w_letter = 5'd18;
      8'h1B: w_letter = 5'd19;  8'h2C: w_letter = 5'd20;  8'h3C: w_letter = 5'd21;
      8'h2A: w_letter = 5'd22;  8'h1D: w_letter = 5'd23;  8'h22: w_letter = 5'd24;
      8'h35: w_letter = 5'd25;  8'h1A: w_letter = 5'd26;
      default: w_letter = 5'd0;
    endcase
  end

  always_comb begin
    w_dig_hit = 1'b1;
    w_digit   = 4'd0;
    w_sym     = 8'h00;
    case (i_code)
      8'h45: begin w_digit = 4'd0; w_sym = 8'h29; end
      8'h16: begin w_digit = 4'd1; w_sym = 8'h21; end
      8'h1E: begin w_digit = 4'd2; w_sym = 8'h40; end
      8'h26: begin w_digit = 4'd3; w_sym = 8'h23; end
      8'h25: begin w_digit = 4'd4; w_sym = 8'h24; end
      8'h2E: begin w_digit = 4'd5; w_sym = 8'h25; end
      8'h36: begin w_digit = 4'd6; w_sym = 8'h5E; end
      8'h3D: begin w_digit = 4'd7; w_sym = 8'h26; end
      8'h3E: begin w_digit = 4'd8; w_sym = 8'h2A; end
      8'h46: begin w_digit = 4'd9; w_sym = 8'h28; end
      default: w_dig_hit = 1'b0;
    endcase
  end

  always_comb begin
    o_valid = 1'b0;
    o_ascii = 8'h00;
    if (!i_ext && (w_letter != 5'd0)) begin
      o_valid = 1'b1;
      if (i_ctrl)                o_ascii = {3'b000, w_letter};
      else if (i_shift ^ i_caps) o_ascii = 8'h40 + {3'b000, w_letter};
      else                       o_ascii = 8'h60 + {3'b000, w_letter};
    end else if (!i_ext && w_dig_hit) begin
      o_valid = 1'b1;
      o_ascii = i_shift ? w_sym : (8'h30 + {4'h0, w_digit});
    end else begin
      o_valid = 1'b1;
      case ({i_ext, i_code})
        {1'b0, 8'h29}: o_ascii = 8'h20;
        {1'b0, 8'h5A}: o_ascii = 8'h0D;
        {1'b1, 8'h5A}: o_ascii = 8'h0D;
        {1'b0, 8'h66}: o_ascii = 8'h08;
        {1'b0, 8'h76}: o_ascii = 8'h1B;
        {1'b0, 8'h0D}: o_ascii = 8'h09;
        {1'b1, 8'h4A}: o_ascii = 8'h2F;
        default:       o_valid = 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/kbd_scode_dec.sv
// PS/2 Set-2 scan-code decoder: folds E0/F0/E1 prefixes into key events and
// tracks shift/ctrl/caps. ASCII translation is built only with KBD_DEC_ASCII_EN.
module kbd_scode_dec
  import kbd_pkg::*;
#(
  parameter logic [23:0] P_TIMEOUT = 24'd1_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] scode,
  input  logic       scode_en,
  output logic [7:0] key_code,
  output logic       key_ext,
  output logic       key_brk,
  output logic       key_en,
  output logic [7:0] ascii,
  output logic       ascii_en,
  output logic [2:0] mods,
  output logic       dev_err
);

  kbd_state_t r_state;
  logic [2:0]  r_skip;
  logic [23:0] r_tmo;
  logic [7:0]  r_key_code, r_ascii;
  logic        r_key_ext, r_key_brk, r_key_en, r_ascii_en, r_dev_err;
  logic        r_shift_l, r_shift_r, r_ctrl_l, r_ctrl_r, r_caps, r_caps_held;

  logic       w_idle, w_ext, w_brk, w_drop, w_err;
  logic       w_shift, w_ctrl, w_lut_valid;
  logic [7:0] w_lut_ascii;

  always_comb begin
    w_idle  = (r_state == ST_IDLE);
    w_ext   = (r_state == ST_E0) || (r_state == ST_E0F0);
    w_brk   = (r_state == ST_F0) || (r_state == ST_E0F0);
    w_drop  = w_idle && ((scode == SC_AA) || (scode == SC_FA) ||
                         (scode == SC_FE) || (scode == SC_EE));
    w_err   = w_idle && ((scode == SC_OVR_LO) || (scode == SC_OVR_HI));
    w_shift = r_shift_l | r_shift_r;
    w_ctrl  = r_ctrl_l | r_ctrl_r;
  end

`ifdef KBD_DEC_ASCII_EN
  kbd_ascii_lut u_lut (
    .i_code  (scode),
    .i_ext   (w_ext),
    .i_shift (w_shift),
    .i_caps  (r_caps),
    .i_ctrl  (w_ctrl),
    .o_valid (w_lut_valid),
    .o_ascii (w_lut_ascii)
  );
`else
  assign w_lut_valid = 1'b0;
  assign w_lut_ascii = 8'h00;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_skip      <= 3'd0;
      r_tmo       <= 24'd0;
      r_key_code  <= 8'h00;
      r_key_ext   <= 1'b0;
      r_key_brk   <= 1'b0;
      r_key_en    <= 1'b0;
      r_ascii     <= 8'h00;
      r_ascii_en  <= 1'b0;
      r_dev_err   <= 1'b0;
      r_shift_l   <= 1'b0;
      r_shift_r   <= 1'b0;
      r_ctrl_l    <= 1'b0;
      r_ctrl_r    <= 1'b0;
      r_caps      <= 1'b0;
      r_caps_held <= 1'b0;
    end else begin
      r_key_en   <= 1'b0;
      r_ascii_en <= 1'b0;
      r_dev_err  <= 1'b0;
      if (scode_en) begin
        r_tmo <= 24'd0;
        if (r_state == ST_PAUSE) begin
          r_skip <= r_skip - 3'd1;
          if (r_skip == 3'd1) begin
            r_key_code <= SC_PAUSE;
            r_key_ext  <= 1'b1;
            r_key_brk  <= 1'b0;
            r_key_en   <= 1'b1;
            r_ascii    <= 8'h00;
            r_state    <= ST_IDLE;
          end
        end else if (w_idle && (scode == SC_E0)) begin
          r_state <= ST_E0;
        end else if (w_idle && (scode == SC_F0)) begin
          r_state <= ST_F0;
        end else if (w_idle && (scode == SC_E1)) begin
          r_state <= ST_PAUSE;
          r_skip  <= PAUSE_SKIP;
        end else if ((r_state == ST_E0) && (scode == SC_F0)) begin
          r_state <= ST_E0F0;
        end else if (w_err) begin
          r_dev_err <= 1'b1;
        end else if (!w_drop) begin
          r_key_code <= scode;
          r_key_ext  <= w_ext;
          r_key_brk  <= w_brk;
          r_key_en   <= 1'b1;
          r_ascii    <= (w_lut_valid && !w_brk) ? w_lut_ascii : 8'h00;
          r_ascii_en <= w_lut_valid && !w_brk;
          r_state    <= ST_IDLE;
          if (!w_ext && (scode == SC_LSHIFT)) r_shift_l <= !w_brk;
          if (!w_ext && (scode == SC_RSHIFT)) r_shift_r <= !w_brk;
          if (!w_ext && (scode == SC_CTRL))   r_ctrl_l  <= !w_brk;
          if (w_ext && (scode == SC_CTRL))    r_ctrl_r  <= !w_brk;
          // Only the first make after a release toggles, so typematic repeats are ignored.
          if (!w_ext && (scode == SC_CAPS)) begin
            r_caps_held <= !w_brk;
            if (!w_brk && !r_caps_held) r_caps <= !r_caps;
          end
        end
      end else if (!w_idle) begin
        if (r_tmo == (P_TIMEOUT - 24'd1)) begin
          r_state <= ST_IDLE;
          r_tmo   <= 24'd0;
          r_skip  <= 3'd0;
        end else begin
          r_tmo <= r_tmo + 24'd1;
        end
      end
    end
  end

  assign key_code = r_key_code;
  assign key_ext  = r_key_ext;
  assign key_brk  = r_key_brk;
  assign key_en   = r_key_en;
  assign ascii    = r_ascii;
  assign ascii_en = r_ascii_en;
  assign dev_err  = r_dev_err;

  always_comb begin
    mods            = 3'b000;
    mods[MOD_SHIFT] = w_shift;
    mods[MOD_CTRL]  = w_ctrl;
    mods[MOD_CAPS]  = r_caps;
  end

endmodule
